// File: rtl/ascii_frame_sequencer.sv
// Serialises N_DIGITS latched BCD digits, MSB first, plus a terminator character to a UART
// transmitter through a send/done handshake. Optional leading-zero blanking and bad-digit marking.
module ascii_frame_sequencer #(
  parameter int unsigned N_DIGITS  = 3,
  parameter logic [6:0]  TERM_CHAR = 7'h23,
  parameter bit          LZ_BLANK  = 1'b0,
  parameter logic [6:0]  BAD_CHAR  = 7'h3F,
  localparam int unsigned IdxW     = $clog2(N_DIGITS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic                  tx_done_i,
  output logic                  tx_send_o,
  output logic [6:0]            tx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [IdxW-1:0]       char_idx_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIGITS);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StFin} state_e;

  state_e                state_q;
  logic [4*N_DIGITS-1:0] digits_q;
  logic [IdxW-1:0]       idx_q;
  logic                  tx_send_q;
  logic [6:0]            tx_data_q;
  logic                  busy_q;
  logic                  done_q;

  logic [IdxW-1:0]       idx_d;
  logic [6:0]            next_char;

  // Character at position idx; blanking stays active only while every earlier digit is zero.
  function automatic logic [6:0] char_of(logic [4*N_DIGITS-1:0] d, logic [IdxW-1:0] idx);
    logic       lead_zero;
    logic [3:0] dig;
    char_of   = TERM_CHAR;
    lead_zero = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      dig = d[4*(N_DIGITS-1-j) +: 4];
      if (j == 32'(idx)) begin
        if (dig > 4'd9) begin
          char_of = BAD_CHAR;
        end else if (LZ_BLANK && lead_zero && (dig == 4'd0) && (j != N_DIGITS - 1)) begin
          char_of = 7'h20;
        end else begin
          char_of = {3'b011, dig};
        end
      end
      if (dig != 4'd0) lead_zero = 1'b0;
    end
  endfunction

  always_comb begin
    idx_d     = idx_q + 1'b1;
    next_char = char_of(digits_q, idx_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      digits_q  <= '0;
      idx_q     <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            // First character comes straight from the input so tx_send follows start by one cycle.
            digits_q  <= digits_i;
            idx_q     <= '0;
            tx_send_q <= 1'b1;
            tx_data_q <= char_of(digits_i, '0);
            busy_q    <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: state_q <= StWait;
        StWait: begin
          if (tx_done_i) begin
            if (idx_q == LastIdx) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFin;
            end else begin
              idx_q     <= idx_d;
              tx_send_q <= 1'b1;
              tx_data_q <= next_char;
              state_q   <= StSend;
            end
          end
        end
        StFin: begin
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_send_o  = tx_send_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign char_idx_o = idx_q;

endmodule

// File: tb/tb_ascii_frame_sequencer.sv
// Bench for ascii_frame_sequencer: three configurations checked every cycle against a
// frame-level model, plus literal frame contents for the directed scenarios.
module tb_ascii_frame_sequencer;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start   [NI];
  logic        tx_done [NI];
  logic [19:0] digits  [NI];

  logic       send0, send1, send2;
  logic [6:0] data0, data1, data2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [1:0] idx0, idx1;
  logic [2:0] idx2;

  always #5 clk = ~clk;

  ascii_frame_sequencer u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .digits_i(digits[0][11:0]),
    .tx_done_i(tx_done[0]), .tx_send_o(send0), .tx_data_o(data0), .busy_o(busy0),
    .done_o(done0), .char_idx_o(idx0)
  );

  ascii_frame_sequencer #(.LZ_BLANK(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .digits_i(digits[1][11:0]),
    .tx_done_i(tx_done[1]), .tx_send_o(send1), .tx_data_o(data1), .busy_o(busy1),
    .done_o(done1), .char_idx_o(idx1)
  );

  ascii_frame_sequencer #(.N_DIGITS(5), .TERM_CHAR(7'h0A)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .digits_i(digits[2]),
    .tx_done_i(tx_done[2]), .tx_send_o(send2), .tx_data_o(data2), .busy_o(busy2),
    .done_o(done2), .char_idx_o(idx2)
  );

  logic       o_send [NI];
  logic [6:0] o_data [NI];
  logic       o_busy [NI];
  logic       o_done [NI];
  logic [2:0] o_idx  [NI];

  always_comb begin
    o_send[0] = send0; o_data[0] = data0; o_busy[0] = busy0; o_done[0] = done0;
    o_send[1] = send1; o_data[1] = data1; o_busy[1] = busy1; o_done[1] = done1;
    o_send[2] = send2; o_data[2] = data2; o_busy[2] = busy2; o_done[2] = done2;
    o_idx[0]  = {1'b0, idx0};
    o_idx[1]  = {1'b0, idx1};
    o_idx[2]  = idx2;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Configuration of each instance, as seen by the model.
  int n_dig   [NI] = '{3, 3, 5};
  bit lz_en   [NI] = '{1'b0, 1'b1, 1'b0};
  int term_ch [NI] = '{'h23, 'h23, 'h0A};

  function automatic int ref_char(int n, bit lz, int term, int v, int i);
    int dig;
    bit nz_before;
    if (i == n) return term;
    dig = (v >> (4 * (n - 1 - i))) % 16;
    nz_before = 1'b0;
    for (int k = 0; k < i; k++) begin
      if ((v >> (4 * (n - 1 - k))) % 16 != 0) nz_before = 1'b1;
    end
    if (dig > 9) return 'h3F;
    if (lz && !nz_before && dig == 0 && i < n - 1) return 'h20;
    return 'h30 + dig;
  endfunction

  // Model: frame in flight, position, and whether a tx_done is currently awaited.
  bit m_valid = 1'b0;
  bit m_frame [NI];
  bit m_wait  [NI];
  int m_pos   [NI];
  int m_dig   [NI];
  bit e_send  [NI];
  int e_data  [NI];
  bit e_busy  [NI];
  bit e_done  [NI];
  int e_idx   [NI];
  bit e_known [NI];

  int cap      [NI][16];
  int cap_n    [NI];
  int done_cnt [NI];

  initial begin : compare
    bit cur_send, cur_done;
    for (int i = 0; i < NI; i++) begin
      cap_n[i] = 0; done_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (m_valid) begin
          chk($sformatf("u%0d_tx_send", i), int'(o_send[i]), int'(e_send[i]));
          chk($sformatf("u%0d_busy", i), int'(o_busy[i]), int'(e_busy[i]));
          chk($sformatf("u%0d_done", i), int'(o_done[i]), int'(e_done[i]));
          chk($sformatf("u%0d_char_idx", i), int'(o_idx[i]), e_idx[i]);
          if (e_busy[i] || e_known[i])
            chk($sformatf("u%0d_tx_data", i), int'(o_data[i]), e_data[i]);
          if (o_send[i] && cap_n[i] < 16) begin
            cap[i][cap_n[i]] = int'(o_data[i]);
            cap_n[i]++;
          end
          if (o_done[i]) done_cnt[i]++;
        end
        if (rst) begin
          e_send[i] = 1'b0; e_data[i] = 0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
          e_idx[i] = 0; e_known[i] = 1'b1;
          m_frame[i] = 1'b0; m_wait[i] = 1'b0; m_pos[i] = 0;
        end else begin
          cur_send  = e_send[i];
          cur_done  = e_done[i];
          e_send[i] = 1'b0;
          e_done[i] = 1'b0;
          if (cur_done) e_idx[i] = 0;
          if (!m_frame[i] && !cur_done) begin
            if (start[i]) begin
              m_dig[i]   = int'(digits[i]);
              m_pos[i]   = 0;
              m_frame[i] = 1'b1;
              m_wait[i]  = 1'b0;
              e_send[i]  = 1'b1;
              e_busy[i]  = 1'b1;
              e_idx[i]   = 0;
              e_data[i]  = ref_char(n_dig[i], lz_en[i], term_ch[i], m_dig[i], 0);
            end
          end else if (m_frame[i]) begin
            if (cur_send) begin
              m_wait[i] = 1'b1;
            end else if (m_wait[i] && tx_done[i]) begin
              m_wait[i] = 1'b0;
              if (m_pos[i] < n_dig[i]) begin
                m_pos[i]++;
                e_send[i] = 1'b1;
                e_idx[i]  = m_pos[i];
                e_data[i] = ref_char(n_dig[i], lz_en[i], term_ch[i], m_dig[i], m_pos[i]);
              end else begin
                e_done[i]  = 1'b1;
                e_busy[i]  = 1'b0;
                e_known[i] = 1'b0;
                m_frame[i] = 1'b0;
              end
            end
          end
        end
      end
      if (rst) m_valid = 1'b1;
    end
  end

  // Transmitter stand-in: tx_done five cycles after each tx_send; optionally a stray one in SEND.
  bit inj [NI] = '{1'b0, 1'b0, 1'b0};
  int cnt [NI] = '{0, 0, 0};

  initial begin : responder
    for (int i = 0; i < NI; i++) tx_done[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        tx_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) tx_done[i] = 1'b1;
        end
        if (o_send[i]) begin
          cnt[i] = 5;
          if (inj[i]) tx_done[i] = 1'b1;
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(int i, logic [19:0] d);
    digits[i] = d;
    start[i]  = 1'b1;
    step();
    start[i]  = 1'b0;
  endtask

  task automatic wait_done(int i, string nm);
    int k = 0;
    while (!o_done[i] && k < 400) begin
      step();
      k++;
    end
    chk({nm, "_done_seen"}, int'(o_done[i]), 1);
  endtask

  task automatic wait_send_idx(int i, int idx, string nm);
    int k = 0;
    while (!(o_send[i] && int'(o_idx[i]) == idx) && k < 400) begin
      step();
      k++;
    end
    chk({nm, "_send_at_idx"}, int'(o_send[i]), 1);
  endtask

  task automatic check_frame(int i, string nm, int n, logic [47:0] exp);
    chk({nm, "_len"}, cap_n[i], n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_char%0d", nm, k), cap[i][k], int'(exp[8*(n-1-k) +: 8]));
    cap_n[i] = 0;
  endtask

  task automatic check_idle_zero(int i, string nm);
    chk({nm, "_tx_send"}, int'(o_send[i]), 0);
    chk({nm, "_tx_data"}, int'(o_data[i]), 0);
    chk({nm, "_busy"}, int'(o_busy[i]), 0);
    chk({nm, "_done"}, int'(o_done[i]), 0);
    chk({nm, "_char_idx"}, int'(o_idx[i]), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i]  = 1'b0;
      digits[i] = '0;
    end
    step(3);
    rst = 1'b0;
    step();
    check_idle_zero(0, "reset");
    check_idle_zero(2, "reset_u2");

    // Plain frame; first tx_send one cycle after start.
    launch(0, 20'h00123);
    chk("t1_latency", int'(o_send[0]), 1);
    chk("t1_busy", int'(o_busy[0]), 1);
    wait_done(0, "t1");
    chk("t1_fin_busy", int'(o_busy[0]), 0);
    step(2);
    chk("t1_done_count", done_cnt[0], 1);
    check_frame(0, "t1", 4, 48'h31323323);

    launch(0, 20'h001A9);
    wait_done(0, "t2");
    step(2);
    check_frame(0, "t2", 4, 48'h313F3923);

    launch(1, 20'h00007);
    wait_done(1, "t3a");
    step(2);
    check_frame(1, "t3a", 4, 48'h20203723);
    launch(1, 20'h00000);
    wait_done(1, "t3b");
    step(2);
    check_frame(1, "t3b", 4, 48'h20203023);
    launch(1, 20'h00305);
    wait_done(1, "t3c");
    step(2);
    check_frame(1, "t3c", 4, 48'h33303523);

    // Restart attempt and new digits mid-frame must not disturb the frame.
    done_cnt[0] = 0;
    launch(0, 20'h00123);
    wait_send_idx(0, 1, "t4");
    start[0]  = 1'b1;
    digits[0] = 20'h00999;
    step(3);
    start[0]  = 1'b0;
    wait_done(0, "t4");
    step(20);
    chk("t4_done_count", done_cnt[0], 1);
    check_frame(0, "t4", 4, 48'h31323323);

    // Reset while waiting on char 2 abandons the frame.
    done_cnt[0] = 0;
    launch(0, 20'h00123);
    wait_send_idx(0, 2, "t5");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero(0, "t5_after_reset");
    step(10);
    chk("t5_no_done", done_cnt[0], 0);
    cap_n[0] = 0;
    launch(0, 20'h00456);
    wait_done(0, "t5b");
    step(2);
    check_frame(0, "t5b", 4, 48'h34353623);

    // Five digits, stray tx_done in SEND, start in FIN ignored, start right after accepted.
    done_cnt[2] = 0;
    inj[2] = 1'b1;
    launch(2, 20'h90817);
    wait_done(2, "t6a");
    check_frame(2, "t6a", 6, 48'h39303831370A);
    start[2] = 1'b1;
    step();
    chk("t6_fin_start_ignored", int'(o_send[2]), 0);
    step();
    start[2] = 1'b0;
    chk("t6_next_start_taken", int'(o_send[2]), 1);
    wait_done(2, "t6b");
    step(2);
    check_frame(2, "t6b", 6, 48'h39303831370A);
    chk("t6_done_count", done_cnt[2], 2);
    inj[2] = 1'b0;

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
